// File: rtl/video_pattern_gen.sv
// Test-pattern raster generator: runtime NTSC/PAL vertical timing, pixel clock enable,
// and noise / colour-bar / grid / solid patterns with a per-channel mask.
module video_pattern_gen #(
  parameter int DW        = 8,
  parameter int CE_DIV    = 4,
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 44,
  parameter int VN_ACTIVE = 240,
  parameter int VN_FP     = 3,
  parameter int VN_SYNC   = 3,
  parameter int VN_BP     = 16,
  parameter int VP_ACTIVE = 288,
  parameter int VP_FP     = 3,
  parameter int VP_SYNC   = 3,
  parameter int VP_BP     = 18
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pal,
  input  logic [1:0]      mode,
  input  logic [1:0]      col,
  input  logic [3*DW-1:0] fill,
  output logic            ce_pix,
  output logic            hblank,
  output logic            vblank,
  output logic            hsync,
  output logic            vsync,
  output logic            frame_start,
  output logic [11:0]     x,
  output logic [9:0]      y,
  output logic [DW-1:0]   r,
  output logic [DW-1:0]   g,
  output logic [DW-1:0]   b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VN_TOTAL = VN_ACTIVE + VN_FP + VN_SYNC + VN_BP;
  localparam int VP_TOTAL = VP_ACTIVE + VP_FP + VP_SYNC + VP_BP;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int DIV_W    = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CE_DIV - 2);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HS_BEG     = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] BAR_LAST   = 12'(BAR_W - 1);

  logic [DIV_W-1:0] div;
  logic [11:0]      h;
  logic [9:0]       v;
  logic [11:0]      bar_cnt;
  logic [2:0]       bar_idx;
  logic [15:0]      lfsr;
  logic             pal_q;
  logic [1:0]       mode_q;

  logic [9:0]       v_active;
  logic [9:0]       v_last;
  logic [9:0]       vs_beg;
  logic [9:0]       vs_end;

  logic             tick;
  logic             h_act;
  logic             v_act;
  logic             grid_on;
  logic [15:0]      lfsr_next;
  logic [DW-1:0]    pr;
  logic [DW-1:0]    pg;
  logic [DW-1:0]    pb;

  // Vertical geometry follows the standard latched at the last frame boundary.
  always_comb begin
    if (pal_q) begin
      v_active = 10'(VP_ACTIVE);
      v_last   = 10'(VP_TOTAL - 1);
      vs_beg   = 10'(VP_ACTIVE + VP_FP);
      vs_end   = 10'(VP_ACTIVE + VP_FP + VP_SYNC);
    end else begin
      v_active = 10'(VN_ACTIVE);
      v_last   = 10'(VN_TOTAL - 1);
      vs_beg   = 10'(VN_ACTIVE + VN_FP);
      vs_end   = 10'(VN_ACTIVE + VN_FP + VN_SYNC);
    end
  end

  assign tick      = (div == DIV_LAST);
  assign h_act     = (h < H_ACT);
  assign v_act     = (v < v_active);
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign grid_on   = (h[3:0] == 4'd0) || (v[3:0] == 4'd0) ||
                     (h == H_ACT_LAST) || (v == v_active - 10'd1);

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_q)
      2'd0: begin
        pr = lfsr[DW-1:0];
        pg = lfsr[DW-1:0];
        pb = lfsr[DW-1:0];
      end
      2'd1: begin
        pr = {DW{~bar_idx[1]}};
        pg = {DW{~bar_idx[2]}};
        pb = {DW{~bar_idx[0]}};
      end
      2'd2: begin
        pr = {DW{grid_on}};
        pg = {DW{grid_on}};
        pb = {DW{grid_on}};
      end
      default: {pr, pg, pb} = fill;
    endcase
    case (col)
      2'd1:    begin pg = '0; pb = '0; end
      2'd2:    begin pr = '0; pb = '0; end
      2'd3:    begin pr = '0; pg = '0; end
      default: ;
    endcase
    if (!(h_act && v_act)) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  // Outputs register the decode of the current (h, v) on each tick, so x/y
  // always name the pixel the colour and sync outputs describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      lfsr        <= 16'hACE1;
      pal_q       <= 1'b0;
      mode_q      <= 2'd0;
      ce_pix      <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      div         <= tick ? '0 : div + 1'b1;
      ce_pix      <= (div == DIV_PRE);
      frame_start <= 1'b0;
      if (tick) begin
        hblank      <= ~h_act;
        vblank      <= ~v_act;
        hsync       <= (h >= HS_BEG) && (h < HS_END);
        vsync       <= (v >= vs_beg) && (v < vs_end);
        frame_start <= (h == 12'd0) && (v == 10'd0);
        x           <= h;
        y           <= v;
        r           <= pr;
        g           <= pg;
        b           <= pb;
        if (h_act && v_act) begin
          lfsr <= lfsr_next;
        end
        if (h == H_LAST) begin
          h       <= '0;
          bar_cnt <= '0;
          bar_idx <= '0;
          if (v == v_last) begin
            v      <= '0;
            pal_q  <= pal;
            mode_q <= mode;
          end else begin
            v <= v + 10'd1;
          end
        end else begin
          h <= h + 12'd1;
          // Bar index tracks h / BAR_W without a divider.
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 12'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: three instances (small-line timing, full-width line,
// mid-size grid raster) checked against hand-computed pixel values and frame statistics.
module tb_video_pattern_gen;

  localparam int BUDGET = 20000;

  logic clk;
  logic rst_s, rst_d, rst_g;
  logic pal_s, pal_d, pal_g;
  logic [1:0] mode_s, mode_d, mode_g;
  logic [1:0] col_s, col_d, col_g;
  logic [23:0] fill_s, fill_d, fill_g;
  logic ce_s, hb_s, vb_s, hs_s, vs_s, fs_s;
  logic ce_d, hb_d, vb_d, hs_d, vs_d, fs_d;
  logic ce_g, hb_g, vb_g, hs_g, vs_g, fs_g;
  logic [11:0] x_s, x_d, x_g;
  logic [9:0] y_s, y_d, y_g;
  logic [7:0] r_s, g_s, b_s, r_d, g_d, b_d, r_g, g_g, b_g;

  int n_checks = 0;
  int n_err = 0;
  int sel = 0;

  logic mon_ce, mon_hb, mon_vb, mon_fs;
  logic [11:0] mon_x;
  logic [9:0] mon_y;
  logic [23:0] mon_rgb;

  typedef struct {
    int sel;
    logic [1:0] mode;
    logic [1:0] col;
    logic [23:0] fill;
    int px;
    int py;
    logic [23:0] exp_rgb;
    logic ehb;
    logic evb;
  } vec_t;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  video_pattern_gen #(.CE_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4)) u_small (
    .clk(clk), .reset_n(rst_s), .pal(pal_s), .mode(mode_s), .col(col_s), .fill(fill_s),
    .ce_pix(ce_s), .hblank(hb_s), .vblank(vb_s), .hsync(hs_s), .vsync(vs_s),
    .frame_start(fs_s), .x(x_s), .y(y_s), .r(r_s), .g(g_s), .b(b_s));

  video_pattern_gen #(.CE_DIV(2), .VN_ACTIVE(4), .VN_FP(1), .VN_SYNC(1), .VN_BP(2)) u_def (
    .clk(clk), .reset_n(rst_d), .pal(pal_d), .mode(mode_d), .col(col_d), .fill(fill_d),
    .ce_pix(ce_d), .hblank(hb_d), .vblank(vb_d), .hsync(hs_d), .vsync(vs_d),
    .frame_start(fs_d), .x(x_d), .y(y_d), .r(r_d), .g(g_d), .b(b_d));

  video_pattern_gen #(.CE_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
                      .VN_ACTIVE(40), .VN_FP(1), .VN_SYNC(1), .VN_BP(2)) u_grid (
    .clk(clk), .reset_n(rst_g), .pal(pal_g), .mode(mode_g), .col(col_g), .fill(fill_g),
    .ce_pix(ce_g), .hblank(hb_g), .vblank(vb_g), .hsync(hs_g), .vsync(vs_g),
    .frame_start(fs_g), .x(x_g), .y(y_g), .r(r_g), .g(g_g), .b(b_g));

  always_comb begin
    if (sel == 0) begin
      mon_ce = ce_d; mon_hb = hb_d; mon_vb = vb_d; mon_fs = fs_d;
      mon_x = x_d; mon_y = y_d; mon_rgb = {r_d, g_d, b_d};
    end else begin
      mon_ce = ce_g; mon_hb = hb_g; mon_vb = vb_g; mon_fs = fs_g;
      mon_x = x_g; mon_y = y_g; mon_rgb = {r_g, g_g, b_g};
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic vec_t mk(input int s, input logic [1:0] m, input logic [1:0] c,
                              input logic [23:0] f, input int px, input int py,
                              input logic [23:0] rgb, input logic hb, input logic vb);
    vec_t v;
    v.sel = s; v.mode = m; v.col = c; v.fill = f; v.px = px; v.py = py;
    v.exp_rgb = rgb; v.ehb = hb; v.evb = vb;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_fs();
    int n = 0;
    bit ok = 1'b0;
    while (n < BUDGET) begin
      @(negedge clk);
      n++;
      if (mon_fs) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_frame_start: got timeout expected pulse within %0d clk", BUDGET);
    end
  endtask

  // Waits for a fresh arrival of pixel (tx, ty) on the monitored instance.
  task automatic wait_pixel(input int tx, input int ty);
    int n = 0;
    bit ok = 1'b0;
    while (n < BUDGET && int'(mon_x) == tx && int'(mon_y) == ty) begin
      @(negedge clk);
      n++;
    end
    while (n < BUDGET) begin
      @(negedge clk);
      n++;
      if (int'(mon_x) == tx && int'(mon_y) == ty) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_pixel: got timeout expected pixel (%0d,%0d)", tx, ty);
    end
  endtask

  task automatic measure_frame(input int raise_line, output int lines, output int clks,
                               output int ppl, output int hs_x, output int hs_len,
                               output int vs_y, output int ce_cnt, output int ce_adj);
    int px, py;
    logic pce;
    lines = 1; clks = 0; ppl = 1; hs_x = -1; hs_len = 0; vs_y = -1; ce_cnt = 0; ce_adj = 0;
    px = int'(x_s); py = int'(y_s); pce = ce_s;
    while (1'b1) begin
      @(negedge clk);
      clks++;
      if (fs_s) break;
      if (clks >= BUDGET) begin
        n_checks++;
        n_err++;
        $display("FAIL small_frame_timeout: got no frame_start expected one within %0d clk", BUDGET);
        break;
      end
      if (raise_line >= 0 && int'(y_s) == raise_line) pal_s = 1'b1;
      if (ce_s) begin
        ce_cnt++;
        if (pce) ce_adj++;
      end
      pce = ce_s;
      if (vs_s && vs_y < 0) vs_y = int'(y_s);
      if (int'(y_s) != py) lines++;
      if (int'(x_s) != px && y_s == 10'd0) begin
        ppl++;
        if (hs_s) begin
          hs_len++;
          if (hs_x < 0) hs_x = int'(x_s);
        end
      end
      px = int'(x_s);
      py = int'(y_s);
    end
  endtask

  // ---------------- timing / PAL switch on the small instance ----------------
  task automatic run_small();
    int n, lines, clks, ppl, hs_x, hs_len, vs_y, ce_cnt, ce_adj, first_clks;
    n = 0;
    while (!fs_s && n < 100) begin @(negedge clk); n++; end
    check("small_first_fs", 32'(fs_s), 32'd1);

    measure_frame(-1, lines, clks, ppl, hs_x, hs_len, vs_y, ce_cnt, ce_adj);
    check("ntsc_lines", 32'(lines), 32'd262);
    check("ntsc_frame_clk", 32'(clks), 32'd12576);
    check("pixels_per_line", 32'(ppl), 32'd24);
    check("hsync_start_x", 32'(hs_x), 32'd18);
    check("hsync_width", 32'(hs_len), 32'd2);
    check("ntsc_vsync_y", 32'(vs_y), 32'd243);
    check("ce_pix_count", 32'(ce_cnt), 32'd6288);
    check("ce_pix_adjacent", 32'(ce_adj), 32'd0);
    first_clks = clks;

    measure_frame(100, lines, clks, ppl, hs_x, hs_len, vs_y, ce_cnt, ce_adj);
    check("pal_mid_lines", 32'(lines), 32'd262);
    check("pal_mid_vsync_y", 32'(vs_y), 32'd243);
    check("two_frame_clk", 32'(first_clks + clks), 32'd25152);

    measure_frame(-1, lines, clks, ppl, hs_x, hs_len, vs_y, ce_cnt, ce_adj);
    check("pal_lines", 32'(lines), 32'd312);
    check("pal_frame_clk", 32'(clks), 32'd14976);
    check("pal_vsync_y", 32'(vs_y), 32'd291);
  endtask

  // ---------------- pattern checks on the default and grid instances ----------------
  task automatic run_patterns();
    vec_t vecs[17];
    logic [1:0] cur_mode[2];
    logic [15:0] s;
    int n;

    vecs[0]  = mk(0, 2'd1, 2'd0, 24'h0, 0,   0, 24'hFFFFFF, 1'b0, 1'b0);
    vecs[1]  = mk(0, 2'd1, 2'd0, 24'h0, 40,  0, 24'hFFFF00, 1'b0, 1'b0);
    vecs[2]  = mk(0, 2'd1, 2'd0, 24'h0, 80,  0, 24'h00FFFF, 1'b0, 1'b0);
    vecs[3]  = mk(0, 2'd1, 2'd0, 24'h0, 200, 0, 24'hFF0000, 1'b0, 1'b0);
    vecs[4]  = mk(0, 2'd1, 2'd0, 24'h0, 319, 0, 24'h000000, 1'b0, 1'b0);
    vecs[5]  = mk(0, 2'd1, 2'd0, 24'h0, 320, 0, 24'h000000, 1'b1, 1'b0);
    vecs[6]  = mk(0, 2'd1, 2'd1, 24'h0, 40,  1, 24'hFF0000, 1'b0, 1'b0);
    vecs[7]  = mk(0, 2'd1, 2'd0, 24'h0, 0,   4, 24'h000000, 1'b0, 1'b1);
    vecs[8]  = mk(1, 2'd2, 2'd0, 24'h0, 7,   5, 24'h000000, 1'b0, 1'b0);
    vecs[9]  = mk(1, 2'd2, 2'd0, 24'h0, 16,  5, 24'hFFFFFF, 1'b0, 1'b0);
    vecs[10] = mk(1, 2'd2, 2'd0, 24'h0, 63, 20, 24'hFFFFFF, 1'b0, 1'b0);
    vecs[11] = mk(1, 2'd2, 2'd0, 24'h0, 7,  32, 24'hFFFFFF, 1'b0, 1'b0);
    vecs[12] = mk(1, 2'd2, 2'd2, 24'h0, 7,  39, 24'h00FF00, 1'b0, 1'b0);
    vecs[13] = mk(1, 2'd3, 2'd3, 24'h123456, 10, 3, 24'h000056, 1'b0, 1'b0);
    vecs[14] = mk(1, 2'd3, 2'd3, 24'h123456, 70, 3, 24'h000000, 1'b1, 1'b0);
    vecs[15] = mk(1, 2'd3, 2'd0, 24'h123456, 20, 41, 24'h000000, 1'b0, 1'b1);
    vecs[16] = mk(1, 2'd3, 2'd0, 24'h123456, 5,  6, 24'h123456, 1'b0, 1'b0);
    cur_mode[0] = 2'd0;
    cur_mode[1] = 2'd0;

    // Noise right after reset: seed low byte, one Galois step, then green-only mask.
    sel = 0;
    col_d = 2'd0;
    wait_fs();
    check("noise_first", 32'(mon_rgb), 32'hE1E1E1);
    wait_pixel(1, 0);
    check("noise_step1", 32'(mon_rgb), 32'h707070);
    col_d = 2'd2;
    wait_pixel(2, 0);
    check("noise_g_only", 32'(mon_rgb), 32'h003800);
    s = 16'hACE1;
    for (int i = 0; i < 320; i++) s = lfsr_step(s);
    wait_pixel(0, 1);
    check("noise_line1", 32'(mon_rgb), 32'({8'h00, s[7:0], 8'h00}));
    col_d = 2'd0;

    for (int i = 0; i < 17; i++) begin
      sel = vecs[i].sel;
      if (sel == 0) begin
        col_d = vecs[i].col; fill_d = vecs[i].fill; mode_d = vecs[i].mode;
      end else begin
        col_g = vecs[i].col; fill_g = vecs[i].fill; mode_g = vecs[i].mode;
      end
      if (cur_mode[sel] != vecs[i].mode) begin
        wait_fs();
        cur_mode[sel] = vecs[i].mode;
      end
      wait_pixel(vecs[i].px, vecs[i].py);
      check($sformatf("vec%0d_rgb", i), 32'(mon_rgb), 32'(vecs[i].exp_rgb));
      check($sformatf("vec%0d_blank", i), 32'({mon_hb, mon_vb}),
            32'({vecs[i].ehb, vecs[i].evb}));
    end

    // Asynchronous reset mid-line, then restart at (0,0) in noise mode.
    sel = 0;
    col_d = 2'd0;
    wait_pixel(100, 0);
    rst_d = 1'b0;
    #1;
    check("arst_blank", 32'({mon_hb, mon_vb}), 32'd3);
    check("arst_ctrl", 32'({mon_ce, hs_d, vs_d, mon_fs}), 32'd0);
    check("arst_xy", 32'({mon_x, mon_y}), 32'd0);
    check("arst_rgb", 32'(mon_rgb), 32'd0);
    @(negedge clk);
    rst_d = 1'b1;
    n = 0;
    while (!mon_fs && n < 20) begin @(negedge clk); n++; end
    check("arst_fs_latency", 32'(n), 32'd2);
    check("arst_first_xy", 32'({mon_x, mon_y}), 32'd0);
    check("arst_first_rgb", 32'(mon_rgb), 32'hE1E1E1);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_s = 1'b0; rst_d = 1'b0; rst_g = 1'b0;
    pal_s = 1'b0; pal_d = 1'b0; pal_g = 1'b0;
    mode_s = 2'd0; mode_d = 2'd0; mode_g = 2'd0;
    col_s = 2'd0; col_d = 2'd0; col_g = 2'd0;
    fill_s = 24'h0; fill_d = 24'h0; fill_g = 24'h0;
    sel = 0;
    repeat (3) @(negedge clk);
    check("rst_blank", 32'({mon_hb, mon_vb}), 32'd3);
    check("rst_ctrl", 32'({mon_ce, hs_d, vs_d, mon_fs}), 32'd0);
    check("rst_xy", 32'({mon_x, mon_y}), 32'd0);
    check("rst_rgb", 32'(mon_rgb), 32'd0);
    check("rst_small_blank", 32'({hb_s, vb_s, ce_s}), 32'd6);
    rst_s = 1'b1; rst_d = 1'b1; rst_g = 1'b1;
    fork
      run_small();
      run_patterns();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
